// File: rtl/tl_ul_pkg.sv
// TileLink-UL field widths, packed beat layouts and opcodes shared by the link
// buffer and anything that decodes its channels.
package tl_ul_pkg;

  localparam int SOURCE_W = 3;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MASK_W   = 4;

  localparam int A_W = 81;
  localparam int D_W = 46;

  // Bit offsets into the packed beats (LSB of each field)
  localparam int A_OPCODE_LSB  = 78;
  localparam int A_PARAM_LSB   = 75;
  localparam int A_SIZE_LSB    = 72;
  localparam int A_SOURCE_LSB  = 69;
  localparam int A_ADDRESS_LSB = 37;
  localparam int A_MASK_LSB    = 33;
  localparam int A_DATA_LSB    = 1;

  localparam int D_OPCODE_LSB  = 43;
  localparam int D_PARAM_LSB   = 41;
  localparam int D_SIZE_LSB    = 38;
  localparam int D_SOURCE_LSB  = 35;
  localparam int D_SINK_LSB    = 34;
  localparam int D_DENIED_LSB  = 33;
  localparam int D_DATA_LSB    = 1;

  localparam logic [2:0] OP_PUT_FULL        = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] OP_GET             = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [2:0]          size;
    logic [SOURCE_W-1:0] source;
    logic [ADDR_W-1:0]   address;
    logic [MASK_W-1:0]   mask;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [1:0]          param;
    logic [2:0]          size;
    logic [SOURCE_W-1:0] source;
    logic                sink;
    logic                denied;
    logic [DATA_W-1:0]   data;
    logic                corrupt;
  } tl_d_t;

endpackage

// File: rtl/tl_ul_fifo.sv
// Registered FIFO with no bypass; an extra room input lets the owner cap how
// many entries may be occupied below the physical depth.
module tl_ul_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(DEPTH):0]   room,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_bits,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_bits
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rptr, wptr;
  logic [CW-1:0]    count;
  logic             full, enq, deq;

  // Ready depends only on registered state, never on out_ready.
  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !reset && !full && (count < room);
  assign out_valid = (count != '0);
  assign out_bits  = mem[rptr];
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + PW'(1);
      if (deq) rptr <= rptr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem[wptr] <= in_bits;
  end

endmodule

// File: rtl/tl_ul_link_buffer.sv
// TL-UL link buffer: one FIFO per A and D channel, with outstanding-request
// tracking that throttles A admission and flags D beats for unknown sources.
module tl_ul_link_buffer import tl_ul_pkg::*; #(
  parameter int DEPTH        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           c_a_valid,
  output logic           c_a_ready,
  input  logic [A_W-1:0] c_a_bits,
  output logic           m_a_valid,
  input  logic           m_a_ready,
  output logic [A_W-1:0] m_a_bits,
  input  logic           m_d_valid,
  output logic           m_d_ready,
  input  logic [D_W-1:0] m_d_bits,
  output logic           c_d_valid,
  input  logic           c_d_ready,
  output logic [D_W-1:0] c_d_bits,
  output logic [3:0]     inflight,
  output logic           d_orphan
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                a_fifo_ready, a_fifo_valid;
  logic [CW-1:0]       a_room;
  logic [7:0]          pending, pending_nxt;
  logic                a_hs, cd_hs, md_hs, orphan_hit;
  logic [SOURCE_W-1:0] a_src, cd_src, md_src;
  int                  headroom;

  // Limiting A occupancy to MAX_INFLIGHT - inflight is the same as requiring
  // inflight + occupancy < MAX_INFLIGHT at enqueue time.
  always_comb begin
    headroom = MAX_INFLIGHT - int'(inflight);
    a_room   = (headroom < DEPTH) ? CW'(headroom) : CW'(DEPTH);
  end

  assign c_a_ready    = a_fifo_ready;
  assign a_fifo_valid = c_a_valid;

  tl_ul_fifo #(.WIDTH(A_W), .DEPTH(DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset     (reset),
    .room      (a_room),
    .in_valid  (a_fifo_valid),
    .in_ready  (a_fifo_ready),
    .in_bits   (c_a_bits),
    .out_valid (m_a_valid),
    .out_ready (m_a_ready),
    .out_bits  (m_a_bits)
  );

  tl_ul_fifo #(.WIDTH(D_W), .DEPTH(DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset     (reset),
    .room      (CW'(DEPTH)),
    .in_valid  (m_d_valid),
    .in_ready  (m_d_ready),
    .in_bits   (m_d_bits),
    .out_valid (c_d_valid),
    .out_ready (c_d_ready),
    .out_bits  (c_d_bits)
  );

  assign a_hs   = m_a_valid && m_a_ready;
  assign cd_hs  = c_d_valid && c_d_ready;
  assign md_hs  = m_d_valid && m_d_ready;
  assign a_src  = m_a_bits[A_SOURCE_LSB +: SOURCE_W];
  assign cd_src = c_d_bits[D_SOURCE_LSB +: SOURCE_W];
  assign md_src = m_d_bits[D_SOURCE_LSB +: SOURCE_W];

  // Set is applied after clear so a same-source collision leaves the bit set.
  always_comb begin
    pending_nxt = pending;
    if (cd_hs) pending_nxt[cd_src] = 1'b0;
    if (a_hs)  pending_nxt[a_src]  = 1'b1;
  end

  assign orphan_hit = md_hs && !pending[md_src] && !(a_hs && (a_src == md_src));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight <= '0;
      pending  <= '0;
      d_orphan <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      d_orphan <= d_orphan | orphan_hit;
      if (a_hs && !cd_hs && (inflight < 4'(MAX_INFLIGHT)))
        inflight <= inflight + 4'd1;
      else if (!a_hs && cd_hs && (inflight != 4'd0))
        inflight <= inflight - 4'd1;
    end
  end

endmodule

// File: tb/tb_tl_ul_link_buffer.sv
// Bench for tl_ul_link_buffer: directed scenarios then random traffic, all
// compared against a queue-based reference model.
module tb_tl_ul_link_buffer;

  localparam int DEPTH = 2;
  localparam int MAXI  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        c_a_valid, c_a_ready, m_a_valid, m_a_ready;
  logic [80:0] c_a_bits, m_a_bits;
  logic        m_d_valid, m_d_ready, c_d_valid, c_d_ready;
  logic [45:0] m_d_bits, c_d_bits;
  logic [3:0]  inflight;
  logic        d_orphan;

  always #5 clock = ~clock;

  tl_ul_link_buffer #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAXI)) dut (
    .clock(clock), .reset(reset),
    .c_a_valid(c_a_valid), .c_a_ready(c_a_ready), .c_a_bits(c_a_bits),
    .m_a_valid(m_a_valid), .m_a_ready(m_a_ready), .m_a_bits(m_a_bits),
    .m_d_valid(m_d_valid), .m_d_ready(m_d_ready), .m_d_bits(m_d_bits),
    .c_d_valid(c_d_valid), .c_d_ready(c_d_ready), .c_d_bits(c_d_bits),
    .inflight(inflight), .d_orphan(d_orphan)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [80:0] aq[$];
  logic [45:0] dq[$];
  int          m_infl;
  logic [7:0]  m_pend;
  logic        m_orph;
  int          a_total;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aq.delete();
    dq.delete();
    m_infl  = 0;
    m_pend  = '0;
    m_orph  = 1'b0;
    a_total = 0;
  endtask

  function automatic logic [80:0] mk_a(input logic [2:0] op, input logic [2:0] src);
    logic [31:0] addr, data;
    addr = $urandom();
    data = $urandom();
    return {op, 3'd0, 3'd2, src, addr, 4'hf, data, 1'b0};
  endfunction

  function automatic logic [45:0] mk_d(input logic [2:0] op, input logic [2:0] src);
    logic [31:0] data;
    data = $urandom();
    return {op, 2'd0, 3'd2, src, 1'b0, 1'b0, data, 1'b0};
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, "_c_a_ready"}, 128'(c_a_ready), 128'(0));
    chk({tag, "_m_a_valid"}, 128'(m_a_valid), 128'(0));
    chk({tag, "_m_d_ready"}, 128'(m_d_ready), 128'(0));
    chk({tag, "_c_d_valid"}, 128'(c_d_valid), 128'(0));
    chk({tag, "_inflight"},  128'(inflight),  128'(0));
    chk({tag, "_d_orphan"},  128'(d_orphan),  128'(0));
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model.
  task automatic step(input logic cav, input logic [80:0] cab, input logic mar,
                      input logic mdv, input logic [45:0] mdb, input logic cdr);
    logic        e_car, e_mdr, a_enq, a_deq, d_enq, d_deq;
    logic [80:0] ah;
    logic [45:0] dh;
    logic [2:0]  as, cs, ds;
    @(negedge clock);
    c_a_valid = cav; c_a_bits = cab; m_a_ready = mar;
    m_d_valid = mdv; m_d_bits = mdb; c_d_ready = cdr;
    #1;
    e_car = (aq.size() < DEPTH) && ((m_infl + aq.size()) < MAXI);
    e_mdr = (dq.size() < DEPTH);
    ah = (aq.size() > 0) ? aq[0] : '0;
    dh = (dq.size() > 0) ? dq[0] : '0;
    chk("c_a_ready", 128'(c_a_ready), 128'(e_car));
    chk("m_a_valid", 128'(m_a_valid), 128'(aq.size() > 0));
    if (aq.size() > 0) chk("m_a_bits", 128'(m_a_bits), 128'(ah));
    chk("m_d_ready", 128'(m_d_ready), 128'(e_mdr));
    chk("c_d_valid", 128'(c_d_valid), 128'(dq.size() > 0));
    if (dq.size() > 0) chk("c_d_bits", 128'(c_d_bits), 128'(dh));
    chk("inflight", 128'(inflight), 128'(m_infl));
    chk("d_orphan", 128'(d_orphan), 128'(m_orph));
    chk("pending", 128'(dut.pending), 128'(m_pend));

    a_deq = (aq.size() > 0) && mar;
    d_deq = (dq.size() > 0) && cdr;
    a_enq = cav && e_car;
    d_enq = mdv && e_mdr;
    as = ah[71:69];
    cs = dh[37:35];
    ds = mdb[37:35];
    if (d_enq && !m_pend[ds] && !(a_deq && as == ds)) m_orph = 1'b1;
    if (d_deq) m_pend[cs] = 1'b0;
    if (a_deq) m_pend[as] = 1'b1;
    if (a_deq && !d_deq && m_infl < MAXI) m_infl++;
    else if (d_deq && !a_deq && m_infl > 0) m_infl--;
    if (a_deq) void'(aq.pop_front());
    if (d_deq) void'(dq.pop_front());
    if (a_enq) begin aq.push_back(cab); a_total++; end
    if (d_enq) dq.push_back(mdb);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  function automatic logic [2:0] pick_src();
    logic [2:0] r;
    if (m_pend != '0 && $urandom_range(0, 3) != 0)
      for (int k = 0; k < 16; k++) begin
        r = 3'($urandom_range(0, 7));
        if (m_pend[r]) return r;
      end
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic async_reset(input string tag);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 chk_quiet(tag);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    c_a_valid = 1'b0; c_a_bits = '0; m_a_ready = 1'b0;
    m_d_valid = 1'b0; m_d_bits = '0; c_d_ready = 1'b0;
    model_reset();
    #1 chk_quiet("rst");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Get to source 3 passes through unchanged, one cycle later
    step(1'b1, mk_a(3'd4, 3'd3), 1'b1, 1'b0, '0, 1'b1);
    idle(2);
    chk("get_inflight", 128'(inflight), 128'(1));
    chk("get_pend3", 128'(dut.pending[3]), 128'(1));

    // Admission closes at MAX_INFLIGHT until an AccessAck retires one
    for (int i = 0; i < 6; i++) step(1'b1, mk_a(3'd4, 3'(4 + i)), 1'b1, 1'b0, '0, 1'b1);
    chk("max_held", 128'(c_a_ready), 128'(0));
    step(1'b0, '0, 1'b1, 1'b1, mk_d(3'd0, 3'd3), 1'b1);
    idle(2);
    chk("max_reopen", 128'(c_a_ready), 128'(1));
    step(1'b0, '0, 1'b1, 1'b1, mk_d(3'd0, 3'd4), 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, mk_d(3'd0, 3'd5), 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, mk_d(3'd0, 3'd6), 1'b1);
    idle(2);

    // Fill A FIFO with the manager stalled, then drain in order
    step(1'b1, mk_a(3'd0, 3'd1), 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, mk_a(3'd1, 3'd2), 1'b0, 1'b0, '0, 1'b1);
    step(1'b1, mk_a(3'd4, 3'd7), 1'b0, 1'b0, '0, 1'b1);
    idle(3);
    chk("a_rptr", 128'(dut.u_a_fifo.rptr), 128'(a_total % DEPTH));
    chk("a_wptr", 128'(dut.u_a_fifo.wptr), 128'(a_total % DEPTH));
    step(1'b0, '0, 1'b1, 1'b1, mk_d(3'd0, 3'd1), 1'b1);
    step(1'b0, '0, 1'b1, 1'b1, mk_d(3'd1, 3'd2), 1'b1);
    idle(2);

    // Same-source A issue and D retire in one cycle
    step(1'b1, mk_a(3'd4, 3'd2), 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step(1'b1, mk_a(3'd4, 3'd2), 1'b0, 1'b1, mk_d(3'd1, 3'd2), 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    chk("same_src_infl", 128'(inflight), 128'(1));
    chk("same_src_pend2", 128'(dut.pending[2]), 128'(1));

    // AccessAck for a source nothing is waiting on
    step(1'b0, '0, 1'b1, 1'b1, mk_d(3'd0, 3'd5), 1'b1);
    idle(4);
    chk("orphan_sticky", 128'(d_orphan), 128'(1));

    // Reset with both FIFOs holding two beats
    step(1'b1, mk_a(3'd4, 3'd6), 1'b0, 1'b1, mk_d(3'd0, 3'd2), 1'b0);
    step(1'b1, mk_a(3'd4, 3'd0), 1'b0, 1'b1, mk_d(3'd0, 3'd6), 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    async_reset("midrst");
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);

    // Random traffic with one asynchronous reset part-way through
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), mk_a(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           mk_d(3'($urandom_range(0, 1)), pick_src()), 1'($urandom_range(0, 3) != 0));
      if (n == 300) async_reset("rndrst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tl_ul_link_buffer.md
TL_UL_LINK_BUFFER -- requirements
Module: tl_ul_link_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entries per channel FIFO (power of two, 2..8).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 4, meaning maximum A requests forwarded without a D response (1..8).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: port `clock`, input, 1 bit, sole clock.
REQ-004 SHALL have port `reset`, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have ports `c_a_valid` input 1, `c_a_ready` output 1, and `c_a_bits` input 81, the client A channel.
REQ-006 SHALL have ports `m_a_valid` output 1, `m_a_ready` input 1, and `m_a_bits` output 81, the manager A channel.
REQ-007 SHALL have ports `m_d_valid` input 1, `m_d_ready` output 1, and `m_d_bits` input 46, the manager D channel.
REQ-008 SHALL have ports `c_d_valid` output 1, `c_d_ready` input 1, and `c_d_bits` output 46, the client D channel.
REQ-009 SHALL have port `inflight` output 4, the count of outstanding requests.
REQ-010 SHALL have port `d_orphan` output 1, a sticky flag for a D beat whose source is not outstanding.

Function
REQ-011 A bits SHALL be packed, MSB first: opcode[3], param[3], size[3], source[3], address[32], mask[4], data[32], corrupt[1].
REQ-012 D bits SHALL be packed, MSB first: opcode[3], param[2], size[3], source[3], sink[1], denied[1], data[32], corrupt[1].
REQ-013 Each channel SHALL be an independent DEPTH-entry FIFO with a one-cycle minimum latency; a beat accepted in cycle N is presentable in cycle N+1, with no combinational valid-to-ready or ready-to-valid path.
REQ-014 An enqueue SHALL occur on valid&&ready; a dequeue SHALL occur on the downstream valid&&ready; order SHALL be preserved and bits SHALL be unaltered.
REQ-015 `c_a_ready` SHALL be high iff the A FIFO is not full AND inflight+A-FIFO-occupancy < MAX_INFLIGHT.
REQ-016 `m_d_ready` SHALL be high iff the D FIFO is not full.
REQ-017 Full FIFO with simultaneous enqueue and dequeue: ready SHALL be low, so no enqueue occurs.
REQ-018 Empty FIFO: valid SHALL be low, and there SHALL be no bypass.
REQ-019 Read and write pointers SHALL be log2(DEPTH) bits, wrapping modulo DEPTH; a separate count of width log2(DEPTH)+1 SHALL determine full/empty.
REQ-020 `inflight` SHALL increment on an m_a handshake, decrement on a c_d handshake, be unchanged when both occur in the same cycle, and never exceed MAX_INFLIGHT or underflow.
REQ-021 An 8-bit pending-source vector SHALL set bit[source] on an m_a handshake and clear bit[source] on a c_d handshake; when both target the same source in the same cycle, set SHALL win.
REQ-022 An m_d handshake whose source bit is clear and is not being set in the same cycle SHALL set `d_orphan` the next cycle; `d_orphan` SHALL clear only on reset.
REQ-023 An orphan D beat SHALL still be forwarded unchanged and SHALL NOT decrement `inflight` below 0.

Reset
REQ-024 On reset assertion, pointers, counts, `inflight`, the pending vector, and `d_orphan` SHALL go to 0 immediately (asynchronous).
REQ-025 During reset and after reset, `c_a_ready`, `m_a_valid`, `m_d_ready`, and `c_d_valid` SHALL be 0.
REQ-026 FIFO data storage SHALL NOT be reset.
REQ-027 Reset mid-transaction SHALL discard all buffered beats; the first cycle after deassertion SHALL show both FIFOs empty with ready high.

Structure
REQ-028 Package tl_ul_pkg SHALL hold the A/D field widths, packed A/D bit-layout offsets, and TL-UL opcode constants (Get=4, PutFull=0, PutPartial=1, AccessAck=0, AccessAckData=1).
REQ-029 One sub-module, tl_ul_fifo (parameters WIDTH, DEPTH), SHALL be instantiated once per channel.
REQ-030 Inflight/pending tracking SHALL reside in the top module.
REQ-031 The channel outputs SHALL be connectable directly to the existing TileLink monitor assert wrapper.

Verification
REQ-032 A Get to source 3 with m_a_ready=1 SHALL appear on m_a one cycle later with identical bits; inflight=1 and pending[3]=1.
REQ-033 With MAX_INFLIGHT=4 and no D responses, the 5th request SHALL be held with c_a_ready=0 until one AccessAck completes on c_d, after which c_a_ready=1 in the next cycle.
REQ-034 With m_a_ready=0, 2 beats SHALL fill the FIFO (c_a_ready=0); after 3 cycles of m_a_ready=1, both SHALL drain in order and the pointers SHALL wrap to 0.
REQ-035 Simultaneous m_a handshake of source 2 and c_d handshake of source 2 SHALL leave inflight unchanged and pending[2]=1.
REQ-036 An AccessAck with source 5 and pending[5]=0 SHALL be forwarded, with d_orphan=1 the next cycle and held until reset.
REQ-037 Reset asserted with 2 beats in each FIFO SHALL drop all valids the same cycle and leave inflight=0 and d_orphan=0.
